// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: multi-channel SAR conversion sequencer with a result FIFO.
// Rev 1.0 - initial release.
`default_nettype none

module sar_scan_sequencer #(
  parameter  int WIDTH  = 8,
  parameter  int NCH    = 4,
  parameter  int TRACK  = 4,
  parameter  int SETTLE = 3,
  parameter  int DEPTH  = 4,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             comp_in,
  output logic [CHW-1:0]   mux_sel,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CHW-1:0]   res_ch,
  output logic             overflow
);

  localparam int IW     = $clog2(WIDTH);
  localparam int CNTMAX = (TRACK > SETTLE) ? TRACK : SETTLE;
  localparam int CW     = $clog2(CNTMAX + 1);
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_CONV, S_STORE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] acc;
  logic [CHW-1:0]   ch, next_ch;
  logic [NCH-1:0]   mask;
  logic             cont_q, stop_pend, has_next;
  logic             accept, push, done_nxt;

  function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (m[k]) lowest_set = CHW'(k);
  endfunction

  always_comb begin
    has_next = 1'b0;
    next_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(ch))) begin
        has_next = 1'b1;
        next_ch  = CHW'(k);
      end
    end
  end

  assign accept = (state == S_IDLE) && start && (|ch_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_TRACK;
      S_TRACK: if (cnt == CW'(TRACK - 1)) state_nxt = S_CONV;
      S_CONV:  if ((cnt == CW'(SETTLE - 1)) && (bit_idx == '0)) state_nxt = S_STORE;
      S_STORE: begin
        push = 1'b1;
        // A stop arriving in the STORE cycle itself still ends the scan here.
        if (has_next || (cont_q && !(stop_pend || stop))) begin
          state_nxt = S_TRACK;
        end else begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign sample   = (state == S_TRACK);
  assign mux_sel  = busy ? ch : '0;
  assign dac_code = (state == S_CONV) ? (acc | (WIDTH'(1) << bit_idx)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      acc       <= '0;
      ch        <= '0;
      mask      <= '0;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_nxt;
      if (busy && stop) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mask      <= ch_mask;
            cont_q    <= cont;
            stop_pend <= 1'b0;
            ch        <= lowest_set(ch_mask);
            cnt       <= '0;
          end
        end
        S_TRACK: begin
          if (cnt == CW'(TRACK - 1)) begin
            cnt     <= '0;
            bit_idx <= IW'(WIDTH - 1);
            acc     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CONV: begin
          if (cnt == CW'(SETTLE - 1)) begin
            cnt     <= '0;
            bit_idx <= bit_idx - IW'(1);
            if (comp_in) acc[bit_idx] <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STORE: begin
          cnt <= '0;
          ch  <= has_next ? next_ch : lowest_set(mask);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Result FIFO: first-word fall-through, extra pointer bit separates full from empty.
  logic [CHW+WIDTH-1:0] mem [DEPTH];
  logic [AW:0]          wptr, rptr;
  logic                 empty, full, pop, wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && res_ready;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (wr)  wptr <= wptr + (AW+1)'(1);
      if (accept)                      overflow <= 1'b0;
      else if (push && full && !pop)   overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= {ch, acc};
  end

  assign res_valid          = !empty;
  assign {res_ch, res_data} = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

`default_nettype wire
